// File: rtl/demux_stream_1ton_if.sv
// Stream bundle for the 1-to-N demultiplexer: one input stream, N output channels.
// The demux sits on the slave side; the producer/consumer environment on the master side.
interface demux_stream_1ton_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned SW = (N > 2) ? $clog2(N) : 1;

    logic [W-1:0]   in_data;
    logic [SW-1:0]  in_sel;
    logic           in_bcast;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demux with broadcast, one-entry output slot per channel,
// and a saturating counter of words dropped for an out-of-range select.
module demux_stream_1ton #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_stream_1ton_if.slave     bus,
    output logic [CW-1:0]          drop_cnt
);
    logic [N-1:0][W-1:0] data_q;
    logic [N-1:0]        valid_q;
    logic [CW-1:0]       drop_q;

    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         ready;
    logic         accept;
    logic         drop;

    always_comb begin
        free   = ~valid_q | bus.out_ready;
        sel_ok = (32'(bus.in_sel) < N);
        load   = '0;
        if (rst) begin
            ready = 1'b0;
        end else if (bus.in_bcast) begin
            ready = &free;
        end else if (sel_ok) begin
            ready = free[bus.in_sel];
        end else begin
            ready = 1'b1;  // out-of-range select acts as a sink
        end
        accept = bus.in_valid & ready;
        if (accept) begin
            if (bus.in_bcast) begin
                load = '1;
            end else if (sel_ok) begin
                load[bus.in_sel] = 1'b1;
            end
        end
        drop = accept & ~bus.in_bcast & ~sel_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= '0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                // Load wins over drain so a simultaneous drain+load leaves no bubble.
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= bus.in_data;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (drop && (drop_q != {CW{1'b1}})) begin
                drop_q <= drop_q + CW'(1);
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Self-checking bench: N=4 instance checked every cycle against a behavioural model,
// plus N=3 instances (CW=8 and CW=2) for out-of-range drop counting and saturation.
module tb_demux_stream_1ton;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    demux_stream_1ton_if #(.N(4), .W(8)) ifa ();
    demux_stream_1ton_if #(.N(3), .W(8)) ifb ();
    demux_stream_1ton_if #(.N(3), .W(8)) ifc ();

    logic [7:0] da_cnt;
    logic [7:0] db_cnt;
    logic [1:0] dc_cnt;

    demux_stream_1ton #(.N(4), .W(8), .CW(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .drop_cnt(da_cnt));
    demux_stream_1ton #(.N(3), .W(8), .CW(8)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .drop_cnt(db_cnt));
    demux_stream_1ton #(.N(3), .W(8), .CW(2)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc), .drop_cnt(dc_cnt));

    // N=3 instances share one stimulus set
    logic [7:0] b_data = '0;
    logic [1:0] b_sel = '0;
    logic       b_bcast = 1'b0;
    logic       b_valid = 1'b0;
    logic [2:0] b_ordy = '1;
    assign ifb.in_data = b_data;  assign ifc.in_data = b_data;
    assign ifb.in_sel = b_sel;    assign ifc.in_sel = b_sel;
    assign ifb.in_bcast = b_bcast; assign ifc.in_bcast = b_bcast;
    assign ifb.in_valid = b_valid; assign ifc.in_valid = b_valid;
    assign ifb.out_ready = b_ordy; assign ifc.out_ready = b_ordy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the N=4 instance: one mailbox per channel.
    logic       m_full[4];
    logic [7:0] m_word[4];
    int         m_drops;

    function automatic logic m_ready();
        logic all_free;
        if (rst) return 1'b0;
        all_free = 1'b1;
        for (int k = 0; k < 4; k++)
            if (m_full[k] && !ifa.out_ready[k]) all_free = 1'b0;
        if (ifa.in_bcast) return all_free;
        return !m_full[ifa.in_sel] || ifa.out_ready[ifa.in_sel];
    endfunction

    initial begin
        for (int k = 0; k < 4; k++) begin m_full[k] = 1'b0; m_word[k] = '0; end
        m_drops = 0;
    end

    always @(posedge clk) begin
        logic take;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin m_full[k] = 1'b0; m_word[k] = '0; end
            m_drops = 0;
        end else begin
            take = ifa.in_valid && m_ready();
            for (int k = 0; k < 4; k++) begin
                if (take && (ifa.in_bcast || int'(ifa.in_sel) == k)) begin
                    m_full[k] = 1'b1;
                    m_word[k] = ifa.in_data;
                end else if (ifa.out_ready[k]) begin
                    m_full[k] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mdl_in_ready", ifa.in_ready, m_ready());
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("mdl_valid%0d", k), ifa.out_valid[k], m_full[k]);
                chk($sformatf("mdl_data%0d", k), ifa.out_data[k*8 +: 8], m_word[k]);
            end
            chk("mdl_drop_cnt", da_cnt, 64'(m_drops));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifa.in_data = '0; ifa.in_sel = '0; ifa.in_bcast = 1'b0; ifa.in_valid = 1'b0;
        ifa.out_ready = 4'b1111;
        rst = 1'b1;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("rst_out_valid", ifa.out_valid, 4'b0000);
        chk("rst_out_data", ifa.out_data, 32'h0);
        chk("rst_drop_cnt", da_cnt, 8'd0);
        chk("rst_in_ready", ifa.in_ready, 1'b0);
        rst = 1'b0;

        // Unicast to every channel, all consumers ready
        for (int i = 0; i < 4; i++) begin
            ifa.in_sel = 2'(i); ifa.in_data = 8'(8'hA1 + i); ifa.in_valid = 1'b1;
            #1 chk("t1_in_ready", ifa.in_ready, 1'b1);
            tick();
            chk("t1_out_valid", ifa.out_valid, 64'(4'b0001 << i));
            chk("t1_out_data", ifa.out_data[i*8 +: 8], 8'(8'hA1 + i));
        end
        ifa.in_valid = 1'b0;
        tick();
        chk("t1_drained", ifa.out_valid, 4'b0000);

        // Stalled ch2 holds its word and back-pressures only ch2 traffic
        ifa.out_ready = 4'b1011;
        ifa.in_sel = 2'd2; ifa.in_data = 8'h55; ifa.in_valid = 1'b1;
        #1 chk("t2_ready_first", ifa.in_ready, 1'b1);
        tick();
        ifa.in_data = 8'h66;
        #1 chk("t2_ready_blocked", ifa.in_ready, 1'b0);
        tick();
        chk("t2_hold_valid", ifa.out_valid[2], 1'b1);
        chk("t2_hold_data", ifa.out_data[23:16], 8'h55);
        ifa.in_sel = 2'd0; ifa.in_data = 8'h77;
        #1 chk("t2_ch0_ready", ifa.in_ready, 1'b1);
        tick();
        chk("t2_ch0_valid", ifa.out_valid, 4'b0101);
        chk("t2_ch0_data", ifa.out_data[7:0], 8'h77);
        ifa.in_sel = 2'd2; ifa.in_data = 8'h66; ifa.out_ready = 4'b1111;
        #1 chk("t2_ready_drain", ifa.in_ready, 1'b1);
        tick();
        chk("t2_replace_valid", ifa.out_valid, 4'b0100);
        chk("t2_replace_data", ifa.out_data[23:16], 8'h66);
        ifa.in_valid = 1'b0;
        tick();

        // Broadcast blocked by a full ch1, then lands on all channels together
        ifa.out_ready = 4'b1101;
        ifa.in_sel = 2'd1; ifa.in_data = 8'h11; ifa.in_valid = 1'b1;
        tick();
        ifa.in_bcast = 1'b1; ifa.in_data = 8'h3C;
        #1 chk("t3_bcast_blocked", ifa.in_ready, 1'b0);
        tick();
        chk("t3_only_ch1", ifa.out_valid, 4'b0010);
        chk("t3_ch1_data", ifa.out_data[15:8], 8'h11);
        ifa.out_ready = 4'b1111;
        #1 chk("t3_bcast_ready", ifa.in_ready, 1'b1);
        tick();
        chk("t3_all_valid", ifa.out_valid, 4'b1111);
        chk("t3_all_data", ifa.out_data, 32'h3C3C3C3C);
        ifa.in_valid = 1'b0; ifa.in_bcast = 1'b0;
        tick();
        chk("t3_drained", ifa.out_valid, 4'b0000);

        // Back-to-back stream to ch0
        for (int i = 0; i < 8; i++) begin
            ifa.in_sel = 2'd0; ifa.in_data = 8'(8'h10 + 3 * i); ifa.in_valid = 1'b1;
            #1 chk("t5_in_ready", ifa.in_ready, 1'b1);
            tick();
            chk("t5_valid", ifa.out_valid, 4'b0001);
            chk("t5_data", ifa.out_data[7:0], 8'(8'h10 + 3 * i));
        end
        ifa.in_valid = 1'b0;
        tick();

        // Out-of-range select on N=3: sink, count, saturate at CW=2
        b_sel = 2'd3; b_data = 8'hEE; b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_b_ready", ifb.in_ready, 1'b1);
            chk("t4_c_ready", ifc.in_ready, 1'b1);
            tick();
            chk("t4_b_no_valid", ifb.out_valid, 3'b000);
            chk("t4_c_no_valid", ifc.out_valid, 3'b000);
        end
        b_valid = 1'b0;
        chk("t4_b_drop5", db_cnt, 8'd5);
        chk("t4_c_saturated", dc_cnt, 2'd3);

        // Reset with held words and a non-zero drop count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifa.out_ready = 4'b0101;
        ifa.in_sel = 2'd1; ifa.in_data = 8'h91; ifa.in_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        ifa.in_sel = 2'd3; ifa.in_data = 8'h93;
        tick();
        ifa.in_valid = 1'b0; b_valid = 1'b0;
        chk("t6_pre_valid", ifa.out_valid, 4'b1010);
        chk("t6_pre_data", ifa.out_data, 32'h9300_9100);
        chk("t6_pre_b_drop", db_cnt, 8'd2);
        chk("t6_pre_c_drop", dc_cnt, 2'd2);
        rst = 1'b1;
        #1 chk("t6_rst_in_ready", ifa.in_ready, 1'b0);
        tick();
        chk("t6_rst_valid", ifa.out_valid, 4'b0000);
        chk("t6_rst_data", ifa.out_data, 32'h0);
        chk("t6_rst_b_drop", db_cnt, 8'd0);
        chk("t6_rst_c_drop", dc_cnt, 2'd0);
        rst = 1'b0;
        ifa.out_ready = 4'b1111;
        ifa.in_sel = 2'd1; ifa.in_data = 8'hE1; ifa.in_valid = 1'b1;
        tick();
        chk("t6_after_valid", ifa.out_valid, 4'b0010);
        chk("t6_after_data", ifa.out_data[15:8], 8'hE1);
        ifa.in_valid = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
